// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Purpose  : Multi-cycle sequencer for the EX-stage multiply/divide unit.
//            It runs a MUL_LAT-cycle multiply or a 32-step restoring divide,
//            stalls the pipeline through busy while running, and then writes
//            HI/LO once with a one-cycle done/hilo_we pulse.
// Ports    : clk, rst_n (sync, active-low)
//            start, op_div, op_sign, src_a, src_b, flush  - EX-stage request
//            busy                                          - stall request
//            done, hilo_we, hi_o, lo_o                     - HI/LO write port
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_div,
    input  logic        op_sign,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [5:0] c_mul_last   = 6'(MUL_LAT - 1);
    localparam logic [5:0] c_div_last   = 6'd31;
    localparam bit         c_mul_direct = (MUL_LAT == 1);

    // Sign-extending (or zero-extending) 32x32 multiply, truncated to 64 bits.
    function automatic logic [63:0] f_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        s);
        f_mul = {{32{s & a[31]}}, a} * {{32{s & b[31]}}, b};
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_opa;        // multiplicand, or dividend shifting into quotient
    logic [31:0] r_opb;        // multiplier, or divisor magnitude
    logic [31:0] r_rem;        // partial remainder (always below the divisor)
    logic        r_sign;
    logic        r_qneg;
    logic        r_rneg;

    logic        w_accept;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_rem_shift;
    logic        w_rem_ge;
    logic [31:0] w_rem_sub;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [63:0] w_mul_res;
    logic        w_mul_load;
    logic        w_div_load;

    assign w_accept = start & ~flush & (r_state == ST_IDLE);

    // Divide works on magnitudes; signs are reapplied when the result is written.
    assign w_abs_a = (op_sign & src_a[31]) ? (~src_a + 32'd1) : src_a;
    assign w_abs_b = (op_sign & src_b[31]) ? (~src_b + 32'd1) : src_b;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The remainder stays below the divisor, so the 33-bit shifted value's low
    // 32 bits hold the exact difference whenever the subtraction succeeds.
    // A zero divisor naturally yields an all-ones quotient and remainder = |a|.
    assign w_rem_shift = {r_rem, r_opa[31]};
    assign w_rem_ge    = (w_rem_shift >= {1'b0, r_opb});
    assign w_rem_sub   = w_rem_shift[31:0] - r_opb;
    assign w_rem_next  = w_rem_ge ? w_rem_sub : w_rem_shift[31:0];
    assign w_quo_next  = {r_opa[30:0], w_rem_ge};
    assign w_quo_fix   = r_qneg ? (~w_quo_next + 32'd1) : w_quo_next;
    assign w_rem_fix   = r_rneg ? (~w_rem_next + 32'd1) : w_rem_next;

    // The HI/LO register is the final stage of the multiply chain. With a
    // single-cycle latency the product must come straight from the inputs,
    // because the operand registers are only being loaded on that edge.
    generate
        if (MUL_LAT == 1) begin : g_mul_direct
            assign w_mul_res = f_mul(src_a, src_b, op_sign);
        end else begin : g_mul_piped
            assign w_mul_res = f_mul(r_opa, r_opb, r_sign);
        end
    endgenerate

    // Results are loaded on the edge that enters DONE, so they are valid
    // during the done pulse. A flush on that edge suppresses the write.
    assign w_mul_load = c_mul_direct ? (w_accept & ~op_div)
                                     : ((r_state == ST_MUL) && (r_cnt == c_mul_last) && !flush);
    assign w_div_load = (r_state == ST_DIV) && (r_cnt == c_div_last) && !flush;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // High in the accept cycle so the instruction holds in EX.
                    busy = 1'b1;
                    if (op_div) begin
                        w_state_next = ST_DIV;
                    end else if (c_mul_direct) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                busy = 1'b1;
                if (flush) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == c_mul_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DIV: begin
                busy = 1'b1;
                if (flush) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == c_div_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // The instruction has completed: write even under flush, and
                // ignore start since EX still holds this same instruction.
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign hilo_we = done;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_opa  <= '0;
            r_opb  <= '0;
            r_rem  <= '0;
            r_sign <= 1'b0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            if (w_accept) begin
                r_sign <= op_sign;
                if (op_div) begin
                    r_opa  <= w_abs_a;
                    r_opb  <= w_abs_b;
                    r_rem  <= '0;
                    r_cnt  <= 6'd0;
                    r_qneg <= op_sign & (src_a[31] ^ src_b[31]);
                    r_rneg <= op_sign & src_a[31];
                end else begin
                    r_opa <= src_a;
                    r_opb <= src_b;
                    r_cnt <= 6'd1;
                end
            end
            if (r_state == ST_MUL) begin
                r_cnt <= r_cnt + 6'd1;
            end
            if (r_state == ST_DIV) begin
                r_cnt <= r_cnt + 6'd1;
                r_rem <= w_rem_next;
                r_opa <= w_quo_next;
            end
            if (w_mul_load) begin
                hi_o <= w_mul_res[63:32];
                lo_o <= w_mul_res[31:0];
            end
            if (w_div_load) begin
                hi_o <= w_rem_fix;
                lo_o <= w_quo_fix;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_ctrl
// Purpose  : Directed self-checking bench for muldiv_ctrl (MUL_LAT = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_div;
    logic        op_sign;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_div  (op_div),
        .op_sign (op_sign),
        .src_a   (src_a),
        .src_b   (src_b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hilo_we (hilo_we),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request at cycle T (k = 0) and holds start high, as EX does,
    // until the done pulse or a 60-cycle budget. Returns done's cycle offset
    // (-1 if never seen), the busy-high cycle count and the written HI/LO.
    task automatic run_op(input bit no_wait, input logic div, input logic sign,
                          input logic [31:0] a, input logic [31:0] b,
                          output int done_k, output int busy_n, output logic we,
                          output logic [31:0] hi, output logic [31:0] lo);
        if (!no_wait) @(negedge clk);
        start   = 1'b1;
        op_div  = div;
        op_sign = sign;
        src_a   = a;
        src_b   = b;
        flush   = 1'b0;
        done_k  = -1;
        busy_n  = 0;
        we      = 1'b0;
        hi      = '0;
        lo      = '0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (busy) busy_n++;
            if (done) begin
                done_k = k;
                we     = hilo_we;
                hi     = hi_o;
                lo     = lo_o;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        op_div = 1'b0; op_sign = 1'b0; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (hilo_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", hilo_we); end
        n_checks++; if (hi_o !== 32'h0)   begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi_o); end
        n_checks++; if (lo_o !== 32'h0)   begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mult();
        int dk, bn; logic we; logic [31:0] hi, lo;
        run_op(0, 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, dk, bn, we, hi, lo);
        n_checks++; if (dk !== 2)            begin n_fail++; $display("FAIL mult_done_cycle: got %0d expected 2", dk); end
        n_checks++; if (bn !== 2)            begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 2", bn); end
        n_checks++; if (we !== 1'b1)         begin n_fail++; $display("FAIL mult_hilo_we: got %b expected 1", we); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
        go_idle();
    endtask

    task automatic test_back_to_back();
        int dk, bn; logic we; logic [31:0] hi, lo;
        run_op(0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, dk, bn, we, hi, lo);
        n_checks++; if (dk !== 2)            begin n_fail++; $display("FAIL multu_done_cycle: got %0d expected 2", dk); end
        n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        // start stayed high through DONE; the next start at T+3 must be a fresh accept.
        run_op(0, 1'b0, 1'b0, 32'h00010000, 32'h00010000, dk, bn, we, hi, lo);
        n_checks++; if (dk !== 2)            begin n_fail++; $display("FAIL b2b_done_cycle: got %0d expected 2", dk); end
        n_checks++; if (bn !== 2)            begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected 2", bn); end
        n_checks++; if (hi !== 32'h00000001) begin n_fail++; $display("FAIL b2b_hi: got %h expected 00000001", hi); end
        n_checks++; if (lo !== 32'h00000000) begin n_fail++; $display("FAIL b2b_lo: got %h expected 00000000", lo); end
        go_idle();
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_div();
        int dk, bn; logic we; logic [31:0] hi, lo;
        run_op(0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, dk, bn, we, hi, lo);
        n_checks++; if (dk !== 33)           begin n_fail++; $display("FAIL div_done_cycle: got %0d expected 33", dk); end
        n_checks++; if (bn !== 33)           begin n_fail++; $display("FAIL div_busy_cycles: got %0d expected 33", bn); end
        n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
        go_idle();
        run_op(0, 1'b1, 1'b0, 32'd100, 32'd7, dk, bn, we, hi, lo);
        n_checks++; if (dk !== 33)           begin n_fail++; $display("FAIL divu_done_cycle: got %0d expected 33", dk); end
        n_checks++; if (lo !== 32'd14)       begin n_fail++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
        n_checks++; if (hi !== 32'd2)        begin n_fail++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
        go_idle();
        run_op(0, 1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, dk, bn, we, hi, lo);
        n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_negb_lo: got %h expected fffffffd", lo); end
        n_checks++; if (hi !== 32'h00000001) begin n_fail++; $display("FAIL div_negb_hi: got %h expected 00000001", hi); end
        go_idle();
    endtask

    task automatic test_div_by_zero();
        int dk, bn; logic we; logic [31:0] hi, lo;
        run_op(0, 1'b1, 1'b0, 32'h12345678, 32'd0, dk, bn, we, hi, lo);
        n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu_zero_lo: got %h expected ffffffff", lo); end
        n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL divu_zero_hi: got %h expected 12345678", hi); end
        go_idle();
        run_op(0, 1'b1, 1'b1, 32'hFFFFFFF8, 32'd0, dk, bn, we, hi, lo);
        n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL div_zero_neg_lo: got %h expected 00000001", lo); end
        n_checks++; if (hi !== 32'hFFFFFFF8) begin n_fail++; $display("FAIL div_zero_neg_hi: got %h expected fffffff8", hi); end
        go_idle();
        run_op(0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, dk, bn, we, hi, lo);
        n_checks++; if (dk !== 33)           begin n_fail++; $display("FAIL div_wrap_done_cycle: got %0d expected 33", dk); end
        n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL div_wrap_lo: got %h expected 80000000", lo); end
        n_checks++; if (hi !== 32'h00000000) begin n_fail++; $display("FAIL div_wrap_hi: got %h expected 00000000", hi); end
        go_idle();
    endtask

    task automatic test_flush();
        int dk, bn; logic we; logic [31:0] hi, lo;
        // flush together with start in IDLE: nothing accepted. HI/LO = 0 / 80000000.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op_div = 1'b0; op_sign = 1'b1;
        src_a = 32'd3; src_b = 32'd3;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b expected 0", busy); end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_not_accepted: got busy=%b expected 0", busy); end
        @(negedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_start_no_done: got %b expected 0", done); end

        // flush mid-divide at T+10; restart at T+11 completes at T+44.
        @(negedge clk);
        start = 1'b1; op_div = 1'b1; op_sign = 1'b0; src_a = 32'd100; src_b = 32'd7;
        repeat (10) @(negedge clk);
        start = 1'b0; flush = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_div_busy_t10: got %b expected 1", busy); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_div_busy_t11: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_div_done_t11: got %b expected 0", done); end
        n_checks++; if (hi_o !== 32'h00000000 || lo_o !== 32'h80000000)
            begin n_fail++; $display("FAIL flush_div_hold: got hi=%h lo=%h expected 00000000 80000000", hi_o, lo_o); end
        run_op(1, 1'b1, 1'b0, 32'd1000, 32'd10, dk, bn, we, hi, lo);
        n_checks++; if (dk !== 33)     begin n_fail++; $display("FAIL flush_restart_done_cycle: got %0d expected 33", dk); end
        n_checks++; if (lo !== 32'd100 || hi !== 32'd0)
            begin n_fail++; $display("FAIL flush_restart_result: got hi=%h lo=%h expected 00000000 00000064", hi, lo); end
        go_idle();

        // flush in the last multiply cycle: no write, HI/LO keep 0 / 100.
        @(negedge clk);
        start = 1'b1; op_div = 1'b0; op_sign = 1'b1; src_a = 32'd6; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0; flush = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_mul_busy: got %b expected 1", busy); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_mul_no_done: got %b expected 0", done); end
        n_checks++; if (lo_o !== 32'd100) begin n_fail++; $display("FAIL flush_mul_hold_lo: got %h expected 00000064", lo_o); end

        // flush during DONE: the write still happens.
        @(negedge clk);
        start = 1'b1; op_div = 1'b0; op_sign = 1'b1; src_a = 32'd6; src_b = 32'd7;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        #1;
        n_checks++; if (done !== 1'b1 || hilo_we !== 1'b1)
            begin n_fail++; $display("FAIL flush_done_write: got done=%b we=%b expected 1 1", done, hilo_we); end
        n_checks++; if (lo_o !== 32'd42) begin n_fail++; $display("FAIL flush_done_lo: got %h expected 0000002a", lo_o); end
        go_idle();
        #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL flush_done_after: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_reset_mid_mul();
        int dk, bn; logic we; logic [31:0] hi, lo;
        run_op(0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, dk, bn, we, hi, lo);
        n_checks++; if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE)
            begin n_fail++; $display("FAIL multu_x2: got hi=%h lo=%h expected 00000001 fffffffe", hi, lo); end
        go_idle();
        @(negedge clk);
        start = 1'b1; op_div = 1'b0; op_sign = 1'b0; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || hilo_we !== 1'b0)
            begin n_fail++; $display("FAIL rst_mid_ctrl: got busy=%b done=%b we=%b expected 0 0 0", busy, done, hilo_we); end
        n_checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0)
            begin n_fail++; $display("FAIL rst_mid_hilo: got hi=%h lo=%h expected 0 0", hi_o, lo_o); end
        @(negedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done: got %b expected 0", done); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_div_by_zero();
        test_flush();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle sequencer for the EX-stage multiply/divide resource.
- Accepts mult/multu/div/divu (decoded as FUNC_MUL/FUNC_DIV; OPER_ALUS means signed, OPER_ALUU means unsigned). Runs a MUL_LAT-cycle multiply or a 32-iteration restoring divide.
- Stalls the pipeline while running, then writes HI/LO once.
- Sits between EX operand muxes and the HI/LO register; the hazard unit consumes `busy`.

Parameters:
- MUL_LAT, 2, cycles from accept to done for multiply; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  EX holds a valid mul/div instruction.
- op_div  in  1  1 = divide, 0 = multiply.
- op_sign  in  1  1 = signed (OPER_ALUS), 0 = unsigned (OPER_ALUU).
- src_a  in  32  rs value (multiplicand / dividend).
- src_b  in  32  rt value (multiplier / divisor).
- flush  in  1  exception/eret kill; aborts any operation.
- busy  out  1  stall request to the hazard unit.
- done  out  1  one-cycle pulse; hi_o/lo_o are valid and hilo_we is high.
- hilo_we  out  1  HI/LO write enable (equal to done).
- hi_o  out  32  product[63:32] or remainder.
- lo_o  out  32  product[31:0] or quotient.

Behaviour:
- Reset (rst_n = 0 at a clock edge): state IDLE; busy = 0, done = 0, hilo_we = 0, hi_o = 0, lo_o = 0, counter and operand registers = 0. A reset mid-operation discards the operation.
- States: IDLE, MUL, DIV, DONE.
- IDLE: on start & ~flush, accept (cycle T):
  - latch operands and op_sign;
  - go to MUL (counter = 1) or DIV (counter = 0).
- busy combinationally equals (start & ~flush & state == IDLE) | state == MUL | state == DIV. It is high in the accept cycle so the instruction holds in EX.
- MUL:
  - product formed from the latched operands: signed 64-bit if op_sign, otherwise zero-extended 64-bit. Registered through a chain so that done occurs at T+MUL_LAT.
  - counter increments each cycle; at counter == MUL_LAT-1 go to DONE.
  - MUL_LAT = 1 goes IDLE -> DONE directly.
- DIV (restoring, 1 quotient bit per cycle):
  - At accept, latch |a| and |b| if op_sign, else raw values; record qneg = a[31]^b[31] and rneg = a[31] (both signed only).
  - Cycles T+1..T+32 each perform one shift/subtract step on a 33-bit partial remainder. After the 32nd step, go to DONE.
  - done at T+33.
- DONE (one cycle):
  - done = hilo_we = 1, busy = 0; the pipeline advances this cycle.
  - hi_o/lo_o get the result: divide applies negation of quotient if qneg and of remainder if rneg.
  - start is ignored in DONE (EX still holds the completed instruction); next state is IDLE.
  - A new start is accepted no earlier than the following cycle.
- hi_o/lo_o are registered, update only in DONE, and hold otherwise.
- flush:
  - In any state, next state is IDLE; done is not asserted; hi_o/lo_o unchanged.
  - flush together with start in IDLE means not accepted, busy = 0.
  - flush in DONE: the write still occurs, because the instruction already completed.
- Divide by zero (defined, no trap):
  - unsigned: lo = 0xFFFFFFFF, hi = a;
  - signed: lo = 0xFFFFFFFF if a ≥ 0 else 0x00000001, hi = a.
- 0x80000000 / 0xFFFFFFFF signed gives lo = 0x80000000, hi = 0 (wrap, no overflow flag).
- Remainder sign follows the dividend; quotient truncates toward zero.
- All arithmetic is modulo 2^32 per half; no X propagation from unused operand bits.

Test Plan:
- Signed mult: src_a = 0xFFFFFFFD, src_b = 5, op_sign = 1, start at T -> busy high T..T+1, done at T+2, hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- multu: src_a = src_b = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001. A start held high through DONE is not re-accepted; a new start at T+3 is accepted.
- Signed div: src_a = 0xFFFFFFF9 (−7), src_b = 2, start at T -> busy T..T+32, done only at T+33, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. divu 100/7 gives lo = 14, hi = 2.
- Divide by zero:
  - divu 0x12345678/0 -> lo = 0xFFFFFFFF, hi = 0x12345678;
  - signed −8/0 -> lo = 0x00000001, hi = 0xFFFFFFF8;
  - signed 0x80000000/0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- Flush mid-div: start at T, flush at T+10 -> busy low from T+11, no done pulse, hi/lo keep prior values; start at T+11 accepted with done at T+44.
- Reset mid-mul with rst_n = 0 at T+1 -> all outputs 0 next cycle, no done. flush with start at T -> busy = 0 and nothing accepted.
